multicycle_control_unit: RTL and testbench

Finite-state controller for the multicycle MIPS datapath. It replaces the single-cycle control path and sequences each instruction over several cycles: fetch, decode, execute, memory and writeback. Memory latency is a parameter, so the same controller drives single-cycle or slow shared memory. Unsupported opcodes and functs are trapped in a sticky illegal state.

---
 rtl/multicycle_control_unit_pkg.sv | 37 +++
 rtl/multicycle_control_unit_if.sv | 34 +++
 rtl/multicycle_control_unit_alu_decode.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// the FSM state enum, ALU operation classes, opcode/funct values and alucontrol codes.
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_ILLEGAL
  } state_t;

  // ADD is the all-zero code so states that leave aluop alone default to add
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
// master = controller side, slave = datapath side.
interface multicycle_control_unit_if #(
  parameter int ALUCTRL_W = 3
);
  logic [5:0]           op;
  logic [5:0]           funct;
  logic                 zero;
  logic                 pcen;
  logic                 iord;
  logic                 memwrite;
  logic                 irwrite;
  logic                 regdst;
  logic                 memtoreg;
  logic                 regwrite;
  logic                 alusrca;
  logic [1:0]           alusrcb;
  logic [1:0]           pcsrc;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic                 instr_done;
  logic                 illegal;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, instr_done, illegal
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_control_unit_alu_decode.sv
// Combinational ALU decoder: aluop class plus funct field -> alucontrol code,
// and funct_ok telling DECODE whether an R-type funct is supported.
module alu_decode
  import mctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  aluop_t               aluop,
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 funct_ok
);

  logic [2:0] funct_ctrl;
  logic [2:0] ctrl;

  always_comb begin
    funct_ctrl = ALUC_ADD;
    funct_ok   = 1'b1;
    case (funct)
      F_ADD:   funct_ctrl = ALUC_ADD;
      F_SUB:   funct_ctrl = ALUC_SUB;
      F_AND:   funct_ctrl = ALUC_AND;
      F_OR:    funct_ctrl = ALUC_OR;
      F_SLT:   funct_ctrl = ALUC_SLT;
      default: funct_ok   = 1'b0;
    endcase
  end

  always_comb begin
    ctrl = ALUC_ADD;
    case (aluop)
      ALUOP_SUB:   ctrl = ALUC_SUB;
      ALUOP_FUNCT: ctrl = funct_ctrl;
      default:     ctrl = ALUC_ADD;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with MEM_LATENCY-cycle memory states and a sticky ILLEGAL trap.
// Optional feature: define MCTRL_BNE_EN to decode bne (opcode 000101) as an inverted-sense branch.
module multicycle_control_unit
  import mctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ALUCTRL_W   = 3
) (
  input logic                     clk,
  input logic                     reset_n,
  multicycle_control_unit_if.master bus
);

  localparam int             CW       = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_LATENCY - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          store_q, store_nxt;
  logic          last_wait;
  logic          funct_ok;
  aluop_t        aluop;
  logic          pcwrite, branch, take_branch;
  logic          irwrite_c, regwrite_c, memwrite_c, done_c;
`ifdef MCTRL_BNE_EN
  logic          bne_q, bne_nxt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      cnt     <= '0;
      store_q <= 1'b0;
`ifdef MCTRL_BNE_EN
      bne_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      store_q <= store_nxt;
`ifdef MCTRL_BNE_EN
      bne_q   <= bne_nxt;
`endif
    end
  end

  assign last_wait = (cnt == CNT_LAST);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = '0;
    store_nxt    = store_q;
`ifdef MCTRL_BNE_EN
    bne_nxt      = bne_q;
`endif
    aluop        = ALUOP_ADD;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    irwrite_c    = 1'b0;
    regwrite_c   = 1'b0;
    memwrite_c   = 1'b0;
    done_c       = 1'b0;
    bus.iord     = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        bus.alusrcb = 2'b01;
        if (last_wait) begin
          irwrite_c = 1'b1;
          pcwrite   = 1'b1;
          state_nxt = S_DECODE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        store_nxt   = (bus.op == OP_SW);
`ifdef MCTRL_BNE_EN
        bne_nxt     = 1'b0;
`endif
        case (bus.op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = funct_ok ? S_EXECUTE : S_ILLEGAL;
          OP_BEQ:       state_nxt = S_BRANCH;
`ifdef MCTRL_BNE_EN
          OP_BNE: begin
            state_nxt = S_BRANCH;
            bne_nxt   = 1'b1;
          end
`endif
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_nxt   = store_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        if (last_wait) state_nxt = S_MEMWB;
        else           cnt_nxt   = cnt + CW'(1);
      end
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite_c   = 1'b1;
        done_c       = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWR: begin
        bus.iord = 1'b1;
        if (last_wait) begin
          memwrite_c = 1'b1;
          done_c     = 1'b1;
          state_nxt  = S_FETCH;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_EXECUTE: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        bus.regdst = 1'b1;
        regwrite_c = 1'b1;
        done_c     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
        done_c      = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_nxt   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        done_c     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
        done_c    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ILLEGAL: bus.illegal = 1'b1;
      default:   state_nxt   = S_FETCH;
    endcase
  end

  alu_decode #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decode (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol),
    .funct_ok   (funct_ok)
  );

`ifdef MCTRL_BNE_EN
  assign take_branch = branch & (bus.zero ^ bne_q);
`else
  assign take_branch = branch & bus.zero;
`endif

  // Write enables are gated by reset_n so nothing writes while reset is held
  assign bus.pcen       = reset_n & (pcwrite | take_branch);
  assign bus.irwrite    = reset_n & irwrite_c;
  assign bus.regwrite   = reset_n & regwrite_c;
  assign bus.memwrite   = reset_n & memwrite_c;
  assign bus.instr_done = reset_n & done_c;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit: instruction table on an L=1 instance,
// hand-written lw/sw/reset sequences on an L=3 instance, plus illegal-opcode traps.
module tb_multicycle_control_unit;

  logic clk;
  logic rst1_n, rst3_n;
  int   nchk = 0;
  int   nerr = 0;

  multicycle_control_unit_if #(.ALUCTRL_W(3)) if1 ();
  multicycle_control_unit_if #(.ALUCTRL_W(3)) if3 ();

  multicycle_control_unit #(.MEM_LATENCY(1), .ALUCTRL_W(3)) u_dut1 (
    .clk(clk), .reset_n(rst1_n), .bus(if1.master));
  multicycle_control_unit #(.MEM_LATENCY(3), .ALUCTRL_W(3)) u_dut3 (
    .clk(clk), .reset_n(rst3_n), .bus(if3.master));

  // {pcen, irwrite, regwrite, memwrite, instr_done}
  logic [4:0] en1, en3;
  assign en1 = {if1.pcen, if1.irwrite, if1.regwrite, if1.memwrite, if1.instr_done};
  assign en3 = {if3.pcen, if3.irwrite, if3.regwrite, if3.memwrite, if3.instr_done};

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         len;
    logic [2:0] alu3;
    logic [4:0] last_en;
    logic [1:0] pcsrc_last;
    logic [1:0] rdmt_last;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic [5:0] op, logic [5:0] funct, logic zero,
                              int len, logic [2:0] alu3, logic [4:0] last_en,
                              logic [1:0] pcsrc_last, logic [1:0] rdmt_last);
    vec_t v;
    v.name = name; v.op = op; v.funct = funct; v.zero = zero; v.len = len;
    v.alu3 = alu3; v.last_en = last_en; v.pcsrc_last = pcsrc_last; v.rdmt_last = rdmt_last;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst1_n = 1'b0; rst3_n = 1'b0;
    if1.op = 6'h00; if1.funct = 6'h20; if1.zero = 1'b0;
    if3.op = 6'h00; if3.funct = 6'h20; if3.zero = 1'b0;

    //                 name     op       funct    z  len alu3    {pc,ir,rw,mw,dn} pcsrc  {regdst,memtoreg}
    tbl.push_back(mk("add",  6'h00, 6'h20, 1'b0, 4, 3'b010, 5'b00101, 2'b00, 2'b10));
    tbl.push_back(mk("sub",  6'h00, 6'h22, 1'b0, 4, 3'b110, 5'b00101, 2'b00, 2'b10));
    tbl.push_back(mk("and",  6'h00, 6'h24, 1'b0, 4, 3'b000, 5'b00101, 2'b00, 2'b10));
    tbl.push_back(mk("or",   6'h00, 6'h25, 1'b0, 4, 3'b001, 5'b00101, 2'b00, 2'b10));
    tbl.push_back(mk("slt",  6'h00, 6'h2a, 1'b0, 4, 3'b111, 5'b00101, 2'b00, 2'b10));
    tbl.push_back(mk("addi", 6'h08, 6'h00, 1'b0, 4, 3'b010, 5'b00101, 2'b00, 2'b00));
    tbl.push_back(mk("lw",   6'h23, 6'h00, 1'b0, 5, 3'b010, 5'b00101, 2'b00, 2'b01));
    tbl.push_back(mk("sw",   6'h2b, 6'h00, 1'b0, 4, 3'b010, 5'b00011, 2'b00, 2'b00));
    tbl.push_back(mk("beq1", 6'h04, 6'h00, 1'b1, 3, 3'b110, 5'b10001, 2'b01, 2'b00));
    tbl.push_back(mk("beq0", 6'h04, 6'h00, 1'b0, 3, 3'b110, 5'b00001, 2'b01, 2'b00));
    tbl.push_back(mk("j",    6'h02, 6'h00, 1'b0, 3, 3'b010, 5'b10001, 2'b10, 2'b00));
`ifdef MCTRL_BNE_EN
    tbl.push_back(mk("bne1", 6'h05, 6'h00, 1'b1, 3, 3'b110, 5'b00001, 2'b01, 2'b00));
    tbl.push_back(mk("bne0", 6'h05, 6'h00, 1'b0, 3, 3'b110, 5'b10001, 2'b01, 2'b00));
`endif

    // Reset state: FETCH decode visible, every enable held low
    repeat (2) @(negedge clk);
    chk("rst_en1", 32'(en1), 32'd0);
    chk("rst_en3", 32'(en3), 32'd0);
    chk("rst_alusrcb", 32'(if1.alusrcb), 32'd1);
    chk("rst_iord", 32'(if1.iord), 32'd0);
    chk("rst_illegal", 32'(if1.illegal), 32'd0);

    @(posedge clk); #1 rst1_n = 1'b1;
    foreach (tbl[i]) begin
      if1.op = tbl[i].op; if1.funct = tbl[i].funct; if1.zero = tbl[i].zero;
      for (int c = 1; c <= tbl[i].len; c++) begin
        @(negedge clk);
        chk({tbl[i].name, "_done"}, 32'(if1.instr_done), 32'(c == tbl[i].len));
        chk({tbl[i].name, "_illegal"}, 32'(if1.illegal), 32'd0);
        if (c == 1) chk({tbl[i].name, "_irwrite"}, 32'(if1.irwrite), 32'd1);
        if (c == 3) chk({tbl[i].name, "_alu"}, 32'(if1.alucontrol), 32'(tbl[i].alu3));
        if (c == tbl[i].len) begin
          chk({tbl[i].name, "_en"}, 32'(en1), 32'(tbl[i].last_en));
          chk({tbl[i].name, "_pcsrc"}, 32'(if1.pcsrc), 32'(tbl[i].pcsrc_last));
          chk({tbl[i].name, "_rdmt"}, 32'({if1.regdst, if1.memtoreg}), 32'(tbl[i].rdmt_last));
        end
      end
    end

    // Unknown opcode traps and stays trapped with all enables low
    if1.op = 6'h3f; if1.funct = 6'h00;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        chk("ill_op_flag", 32'(if1.illegal), 32'd1);
        chk("ill_op_en", 32'(en1), 32'd0);
      end
    end
    @(posedge clk); #1 rst1_n = 1'b0;
    #1 chk("ill_rst_flag", 32'(if1.illegal), 32'd0);
    @(posedge clk); #1 rst1_n = 1'b1;
    if1.op = 6'h00; if1.funct = 6'h00;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) chk("ill_fn_fetch", 32'({if1.irwrite, if1.illegal}), 32'd2);
      if (c >= 3) chk("ill_fn_flag", 32'({en1, if1.illegal}), 32'd1);
    end
`ifndef MCTRL_BNE_EN
    @(posedge clk); #1 rst1_n = 1'b0;
    @(posedge clk); #1 rst1_n = 1'b1;
    if1.op = 6'h05;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("bne_off_flag", 32'(if1.illegal), 32'(c == 3));
    end
`endif
    rst1_n = 1'b0;

    // L=3 lw: FETCH 1-3, DECODE 4, MEMADR 5, MEMRD 6-8, MEMWB 9
    @(posedge clk); #1 rst3_n = 1'b1;
    if3.op = 6'h23; if3.funct = 6'h00;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("lw3_irwrite", 32'(if3.irwrite), 32'(c == 3));
      chk("lw3_iord", 32'(if3.iord), 32'(c >= 6 && c <= 8));
      chk("lw3_done", 32'(if3.instr_done), 32'(c == 9));
      if (c == 9) chk("lw3_wb", 32'({if3.regwrite, if3.memtoreg}), 32'd3);
    end

    // L=3 sw: MEMWR 6-8, single memwrite together with instr_done
    if3.op = 6'h2b;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("sw3_memwrite", 32'(if3.memwrite), 32'(c == 8));
      chk("sw3_done", 32'(if3.instr_done), 32'(c == 8));
    end

    // Reset asserted in the first MEMRD cycle of a lw
    if3.op = 6'h23;
    for (int c = 1; c <= 6; c++) @(negedge clk);
    chk("rst3_pre_iord", 32'(if3.iord), 32'd1);
    rst3_n = 1'b0;
    #1;
    chk("rst3_iord", 32'(if3.iord), 32'd0);
    chk("rst3_en", 32'(en3), 32'd0);
    @(posedge clk); #1;
    chk("rst3_hold_en", 32'(en3), 32'd0);
    rst3_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("rst3_refetch", 32'(if3.irwrite), 32'(c == 3));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
